reg_file_cmd_ctrl: RTL



---
 rtl/reg_file_cmd_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/reg_file_cmd_ctrl.sv
// Host-command initiator: decodes RX write/read frames into register-file strobes and returns read data to TX.
// Read: RdEn one cycle after the address byte, TX request two cycles after that; the TX request waits while TX_Busy is high.
module reg_file_cmd_ctrl #(
  parameter int               WIDTH      = 8,
  parameter int               ADDR_WIDTH = 4,
  parameter logic [WIDTH-1:0] WR_CMD     = 8'hAA,
  parameter logic [WIDTH-1:0] RD_CMD     = 8'hBB,
  parameter int               RD_TIMEOUT = 15
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [WIDTH-1:0]      RX_P_DATA,
  input  logic                  RX_D_VLD,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [WIDTH-1:0]      WrData,
  input  logic [WIDTH-1:0]      RdData,
  input  logic                  RdData_Valid,
  output logic [WIDTH-1:0]      TX_P_DATA,
  output logic                  TX_D_VLD,
  input  logic                  TX_Busy,
  output logic                  CMD_ERR
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_ADDR = 3'd1;
  localparam logic [2:0] S_WR_DATA = 3'd2;
  localparam logic [2:0] S_RD_ADDR = 3'd3;
  localparam logic [2:0] S_RD_WAIT = 3'd4;
  localparam logic [2:0] S_TX_SEND = 3'd5;

  localparam int               CNT_W    = $clog2(RD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

  logic [2:0]            state_q,  state_d;
  logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
  logic [WIDTH-1:0]      wdata_q,  wdata_d;
  logic [WIDTH-1:0]      tx_dat_q, tx_dat_d;
  logic [CNT_W-1:0]      cnt_q,    cnt_d;
  logic                  wr_en_q,  wr_en_d;
  logic                  rd_en_q,  rd_en_d;
  logic                  tx_vld_q, tx_vld_d;
  logic                  err_q,    err_d;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    tx_dat_d = tx_dat_q;
    cnt_d    = cnt_q;
    wr_en_d  = 1'b0;
    rd_en_d  = 1'b0;
    tx_vld_d = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == WR_CMD)      state_d = S_WR_ADDR;
          else if (RX_P_DATA == RD_CMD) state_d = S_RD_ADDR;
          else                          err_d   = 1'b1;
        end
      end
      S_WR_ADDR: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
          state_d = S_WR_DATA;
        end
      end
      S_WR_DATA: begin
        if (RX_D_VLD) begin
          wdata_d = RX_P_DATA;
          wr_en_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RD_ADDR: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
          rd_en_d = 1'b1;
          cnt_d   = '0;
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        // RX bytes arriving here and in TX_SEND are deliberately dropped.
        if (RdData_Valid) begin
          tx_dat_d = RdData;
          tx_vld_d = !TX_Busy;
          cnt_d    = '0;
          state_d  = S_TX_SEND;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_TX_SEND: begin
        // The request is registered, so TX_Busy is judged one edge before TX_D_VLD rises.
        if (tx_vld_q)      state_d  = S_IDLE;
        else if (!TX_Busy) tx_vld_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      tx_dat_q <= '0;
      cnt_q    <= '0;
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      tx_vld_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      tx_dat_q <= tx_dat_d;
      cnt_q    <= cnt_d;
      wr_en_q  <= wr_en_d;
      rd_en_q  <= rd_en_d;
      tx_vld_q <= tx_vld_d;
      err_q    <= err_d;
    end
  end

  assign WrEn      = wr_en_q;
  assign RdEn      = rd_en_q;
  assign Address   = addr_q;
  assign WrData    = wdata_q;
  assign TX_P_DATA = tx_dat_q;
  assign TX_D_VLD  = tx_vld_q;
  assign CMD_ERR   = err_q;

endmodule
